// File: rtl/vc_boot_pkg.sv
// Shared types and defaults for the vc boot/reset sequencer.
package vc_boot_pkg;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StSample  = 2'd1,
    StStretch = 2'd2,
    StRun     = 2'd3
  } boot_state_e;

  localparam int unsigned DefStrapW       = 4;
  localparam int unsigned DefStableCycles = 4;
  localparam int unsigned DefRstCycles    = 8;
  localparam int unsigned DefCntW         = 8;
  localparam int unsigned DefWdogCycles   = 1024;

  // Bits needed to represent 0..value-1.
  function automatic int unsigned vc_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vc_strap_filter.sv
// Strap stability filter: reference sample, shared cycle counter and strap latch.
module vc_strap_filter
  import vc_boot_pkg::*;
#(
  parameter int unsigned STRAP_W       = DefStrapW,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               sample_en,
  input  logic               cnt_inc,
  input  logic               cnt_clr,
  input  logic [STRAP_W-1:0] straps,
  output logic [STRAP_W-1:0] strap,
  output logic [CNT_W-1:0]   cnt,
  output logic               done
);

  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);

  logic [STRAP_W-1:0] ref_d, ref_q;
  logic [STRAP_W-1:0] strap_d, strap_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               match;

  assign match = (straps == ref_q);
  // Only meaningful while sampling; the sequencer qualifies it with its state.
  assign done  = match && (cnt_q == StableLast);

  always_comb begin
    ref_d   = ref_q;
    strap_d = strap_q;
    cnt_d   = cnt_q;
    if (load) begin
      ref_d = straps;
      cnt_d = '0;
    end else if (sample_en) begin
      if (!match) begin
        ref_d = straps;
        cnt_d = '0;
      end else if (done) begin
        strap_d = ref_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_inc) begin
      cnt_d = cnt_q + 1'b1;
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q   <= '0;
      strap_q <= '0;
      cnt_q   <= '0;
    end else begin
      ref_q   <= ref_d;
      strap_q <= strap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign strap = strap_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/vc_boot_ctrl.sv
// Reset and boot sequencer between the pad wrapper and the vc core.
// Define VC_BOOT_WDOG_EN to build the RUN-state watchdog.
module vc_boot_ctrl
  import vc_boot_pkg::*;
#(
  parameter int unsigned STRAP_W       = DefStrapW,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned RST_CYCLES    = DefRstCycles,
  parameter int unsigned CNT_W         = DefCntW,
  parameter int unsigned WDOG_CYCLES   = DefWdogCycles
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic [7:0]         ui_in,
  input  logic [7:0]         core_uio_oe,
  input  logic               wdog_kick,
  output logic [7:0]         uio_oe,
  output logic               core_reset,
  output logic [STRAP_W-1:0] strap,
  output logic               running,
  output logic               wdog_fired
);

  localparam int unsigned CntMax = (STABLE_CYCLES > RST_CYCLES) ? STABLE_CYCLES : RST_CYCLES;
  localparam logic [CNT_W-1:0] RstLast = CNT_W'(RST_CYCLES - 1);

  if (STRAP_W < 1 || STRAP_W > 8) begin : gen_bad_strap_w
    $error("vc_boot_ctrl: STRAP_W must be in 1..8");
  end
  if (STABLE_CYCLES < 1 || RST_CYCLES < 1 || WDOG_CYCLES < 1) begin : gen_bad_cycles
    $error("vc_boot_ctrl: cycle parameters must be >= 1");
  end
  if (vc_clog2(CntMax) > CNT_W) begin : gen_bad_cnt_w
    $error("vc_boot_ctrl: CNT_W too narrow for STABLE_CYCLES/RST_CYCLES");
  end

  boot_state_e      state_d, state_q;
  logic             go_hold, load, sample_en, cnt_inc, cnt_clr, done, wdog_expire;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       uio_oe_q;
  logic             core_reset_q, running_q;
  logic             unused_ui;

  assign go_hold   = reset || !ena;
  assign unused_ui = ^ui_in;

  vc_strap_filter #(
    .STRAP_W      (STRAP_W),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_strap_filter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .sample_en(sample_en),
    .cnt_inc  (cnt_inc),
    .cnt_clr  (cnt_clr),
    .straps   (ui_in[STRAP_W-1:0]),
    .strap    (strap),
    .cnt      (cnt),
    .done     (done)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    sample_en = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    if (go_hold) begin
      state_d = StHold;
    end else begin
      unique case (state_q)
        StHold: begin
          load    = 1'b1;
          state_d = StSample;
        end
        StSample: begin
          sample_en = 1'b1;
          if (done) state_d = StStretch;
        end
        StStretch: begin
          if (cnt == RstLast) state_d = StRun;
          else cnt_inc = 1'b1;
        end
        StRun: begin
          // Watchdog expiry re-stretches core reset without resampling straps.
          if (wdog_expire) begin
            state_d = StStretch;
            cnt_clr = 1'b1;
          end
        end
        default: state_d = StHold;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StHold;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      uio_oe_q     <= '0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= (state_d != StRun);
      running_q    <= (state_d == StRun);
      uio_oe_q     <= (state_d == StRun) ? core_uio_oe : 8'h00;
    end
  end

  assign uio_oe     = uio_oe_q;
  assign core_reset = core_reset_q;
  assign running    = running_q;

`ifdef VC_BOOT_WDOG_EN
  localparam int unsigned WdogW = (vc_clog2(WDOG_CYCLES) < 1) ? 1 : vc_clog2(WDOG_CYCLES);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

  logic [WdogW-1:0] wdog_cnt_d, wdog_cnt_q;
  logic             wdog_fired_q;

  // A kick on the expiry cycle wins.
  assign wdog_expire = (state_q == StRun) && !go_hold && !wdog_kick &&
                       (wdog_cnt_q == WdogLast);

  always_comb begin
    wdog_cnt_d = '0;
    if (state_q == StRun && state_d == StRun && !wdog_kick) wdog_cnt_d = wdog_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q   <= '0;
      wdog_fired_q <= 1'b0;
    end else begin
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_fired_q <= wdog_expire;
    end
  end

  assign wdog_fired = wdog_fired_q;
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = wdog_kick;
  assign wdog_expire      = 1'b0;
  assign wdog_fired       = 1'b0;
`endif

endmodule
